dev_bus_decoder: RTL and testbench

Device-side controller between the host arbiter's single shared device bus and four register regions. It decodes each arbitrated access by address, sequences the read or write strobe to the selected region, and returns one `ack_bus` pulse with read data. Unmapped accesses and privilege violations get an error response. Accesses that time out at the device get an error response after `DEV_TO` cycles, well before the arbiter's own timeout.

---
 rtl/dev_bus_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_dev_bus_decoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dev_bus_decoder.sv
// Device-side bus decoder: address/privilege decode, per-region strobe sequencing, device timeout.
// Optional error logging (err_addr/err_code/err_cnt) is enabled by defining DEV_BUS_ERRLOG_EN.
module dev_bus_decoder #(
   parameter int unsigned    AW        = 32,
   parameter int unsigned    DW        = 32,
   parameter int unsigned    BW        = 4,
   parameter logic [AW-1:0]  R0_BASE   = 32'h0000_0000,
   parameter logic [AW-1:0]  R1_BASE   = 32'h0001_0000,
   parameter logic [AW-1:0]  R2_BASE   = 32'h0002_0000,
   parameter logic [AW-1:0]  R3_BASE   = 32'h0003_0000,
   parameter logic [AW-1:0]  R0_MASK   = 32'hFFFF_0000,
   parameter logic [AW-1:0]  R1_MASK   = 32'hFFFF_0000,
   parameter logic [AW-1:0]  R2_MASK   = 32'hFFFF_0000,
   parameter logic [AW-1:0]  R3_MASK   = 32'hFFFF_0000,
   parameter logic [3:0]     PRIV_MASK = 4'b0001,
   parameter int unsigned    DEV_TO    = 256,
   parameter logic [DW-1:0]  ERR_DATA  = 32'hDEAD_BEEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   add_bus,
   input  logic [BW-1:0]   byte_en,
   input  logic            wr_bus,
   input  logic            rd_bus,
   input  logic [DW-1:0]   data_bus_wr,
   input  logic            cpu_bus,
   output logic [DW-1:0]   data_bus_rd,
   output logic            ack_bus,
   output logic [3:0]      dev_sel,
   output logic [AW-1:0]   dev_addr,
   output logic [BW-1:0]   dev_be,
   output logic [DW-1:0]   dev_wdata,
   output logic            dev_wr,
   output logic            dev_rd,
   input  logic [4*DW-1:0] dev_rdata,
   input  logic [3:0]      dev_ack,
`ifdef DEV_BUS_ERRLOG_EN
   output logic [AW-1:0]   err_addr,
   output logic [1:0]      err_code,
   output logic [7:0]      err_cnt,
`endif
   output logic            err
);

   localparam int unsigned CW = $clog2(DEV_TO);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic          op_rd_q, op_rd_d;

   logic [3:0]    sel_d;
   logic [AW-1:0] addr_d;
   logic [BW-1:0] be_d;
   logic [DW-1:0] wdata_d;
   logic          rd_d, wr_d, ack_d, err_d;
   logic [DW-1:0] rdata_d;

   logic [3:0]    hit_vec_c;
   logic          hit_c;
   logic [1:0]    hit_idx_c;
   logic [DW-1:0] slice_c;

   // Region match; the lowest matching index takes priority
   always_comb begin
      hit_vec_c[0] = ((add_bus & R0_MASK) == R0_BASE);
      hit_vec_c[1] = ((add_bus & R1_MASK) == R1_BASE);
      hit_vec_c[2] = ((add_bus & R2_MASK) == R2_BASE);
      hit_vec_c[3] = ((add_bus & R3_MASK) == R3_BASE);
      hit_c        = |hit_vec_c;
      hit_idx_c    = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (hit_vec_c[i]) hit_idx_c = 2'(i);
      end
   end

   // Read data slice of the region currently being accessed
   always_comb begin
      slice_c = '0;
      for (int i = 0; i < 4; i++) begin
         if (idx_q == 2'(i)) slice_c = dev_rdata[i*DW +: DW];
      end
   end

   // Next state and next registered outputs
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      op_rd_d = op_rd_q;
      addr_d  = dev_addr;
      be_d    = dev_be;
      wdata_d = dev_wdata;
      sel_d   = '0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      rdata_d = '0;
      case (state_q)
         S_IDLE: begin
            if (rd_bus || wr_bus) begin
               addr_d  = add_bus;
               be_d    = byte_en;
               wdata_d = data_bus_wr;
               op_rd_d = rd_bus;
               idx_d   = hit_idx_c;
               cnt_d   = '0;
               if (!hit_c || (PRIV_MASK[hit_idx_c] && !cpu_bus)) begin
                  state_d = S_DONE;
                  ack_d   = 1'b1;
                  err_d   = 1'b1;
                  rdata_d = ERR_DATA;
               end else begin
                  state_d = S_ACC;
                  sel_d   = 4'b0001 << hit_idx_c;
                  rd_d    = rd_bus;
                  wr_d    = !rd_bus;
               end
            end
         end
         S_ACC: begin
            if (dev_ack[idx_q]) begin
               state_d = S_DONE;
               ack_d   = 1'b1;
               rdata_d = op_rd_q ? slice_c : '0;
            end else if (cnt_q == CW'(DEV_TO - 1)) begin
               state_d = S_DONE;
               ack_d   = 1'b1;
               err_d   = 1'b1;
               rdata_d = ERR_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
               sel_d = dev_sel;
               rd_d  = dev_rd;
               wr_d  = dev_wr;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         op_rd_q     <= 1'b0;
         dev_sel     <= '0;
         dev_addr    <= '0;
         dev_be      <= '0;
         dev_wdata   <= '0;
         dev_rd      <= 1'b0;
         dev_wr      <= 1'b0;
         ack_bus     <= 1'b0;
         err         <= 1'b0;
         data_bus_rd <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         op_rd_q     <= op_rd_d;
         dev_sel     <= sel_d;
         dev_addr    <= addr_d;
         dev_be      <= be_d;
         dev_wdata   <= wdata_d;
         dev_rd      <= rd_d;
         dev_wr      <= wr_d;
         ack_bus     <= ack_d;
         err         <= err_d;
         data_bus_rd <= rdata_d;
      end
   end

`ifdef DEV_BUS_ERRLOG_EN
   logic [1:0] ecode_c;

   // Only meaningful when err_d is set: ACC errors are timeouts, IDLE errors are decode faults
   always_comb begin
      ecode_c = 2'b01;
      if (state_q == S_ACC) begin
         ecode_c = 2'b11;
      end else if (hit_c) begin
         ecode_c = 2'b10;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_addr <= '0;
         err_code <= '0;
         err_cnt  <= '0;
      end else if (err_d) begin
         err_addr <= addr_d;
         err_code <= ecode_c;
         if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dev_bus_decoder.sv
// Scoreboard bench for dev_bus_decoder: random accesses checked against a region/latency model.
`timescale 1ns/1ps
module tb_dev_bus_decoder;

   localparam int DEV_TO = 256;

   logic         clk = 1'b0;
   logic         reset;
   logic [31:0]  add_bus;
   logic [3:0]   byte_en;
   logic         wr_bus, rd_bus, cpu_bus;
   logic [31:0]  data_bus_wr;
   logic [31:0]  data_bus_rd;
   logic         ack_bus, err;
   logic [3:0]   dev_sel;
   logic [31:0]  dev_addr;
   logic [3:0]   dev_be;
   logic [31:0]  dev_wdata;
   logic         dev_wr, dev_rd;
   logic [127:0] dev_rdata;
   logic [3:0]   dev_ack;
`ifdef DEV_BUS_ERRLOG_EN
   logic [31:0]  err_addr;
   logic [1:0]   err_code;
   logic [7:0]   err_cnt;
`endif

   always #5 clk = ~clk;

   dev_bus_decoder dut (
      .clk(clk), .reset(reset), .add_bus(add_bus), .byte_en(byte_en),
      .wr_bus(wr_bus), .rd_bus(rd_bus), .data_bus_wr(data_bus_wr), .cpu_bus(cpu_bus),
      .data_bus_rd(data_bus_rd), .ack_bus(ack_bus), .dev_sel(dev_sel), .dev_addr(dev_addr),
      .dev_be(dev_be), .dev_wdata(dev_wdata), .dev_wr(dev_wr), .dev_rd(dev_rd),
      .dev_rdata(dev_rdata), .dev_ack(dev_ack),
`ifdef DEV_BUS_ERRLOG_EN
      .err_addr(err_addr), .err_code(err_code), .err_cnt(err_cnt),
`endif
      .err(err)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          strobes;
   } exp_t;

   exp_t sb[$];

   // Current access as seen by the device model and monitor
   int          cur_region = 0;
   int          cur_lat    = 0;
   logic        cur_rd     = 1'b0;
   logic [31:0] cur_addr   = '0;
   logic [31:0] cur_wdata  = '0;
   logic [3:0]  cur_be     = '0;
   logic [31:0] rdv [4];
   int          acc_n      = 0;
   int          strobe_cnt = 0;

   // Device model: acks the addressed region after cur_lat strobe cycles, noise on every other ack bit
   always @(negedge clk) begin : device
      logic [3:0] a;
      a = 4'($urandom);
      if (dev_rd || dev_wr) begin
         a[cur_region] = (acc_n == cur_lat);
         chk("dev_addr", dev_addr, cur_addr);
         if (dev_wr) begin
            chk("dev_wdata", dev_wdata, cur_wdata);
            chk("dev_be", 32'(dev_be), 32'(cur_be));
         end
         acc_n++;
      end else begin
         acc_n = 0;
      end
      dev_ack = a;
   end

   // Monitor: strobe shape while accessing, scoreboard pop on every ack_bus
   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset) begin
         strobe_cnt = 0;
      end else begin
         if (dev_rd || dev_wr) begin
            strobe_cnt++;
            chk("dev_sel", 32'(dev_sel), 32'(4'b0001 << cur_region));
            chk("dev_rd_op", 32'(dev_rd), 32'(cur_rd));
            chk("dev_wr_op", 32'(dev_wr), 32'(!cur_rd));
         end
         if (ack_bus) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: ack_bus=1 with no access outstanding at %0t", $time);
            end else begin
               e = sb.pop_front();
               chk("ack_data", data_bus_rd, e.data);
               chk("ack_err", 32'(err), 32'(e.err));
               chk("strobe_cycles", 32'(strobe_cnt), 32'(e.strobes));
               chk("done_quiet", {dev_sel, 2'b00, dev_rd, dev_wr}, 32'd0);
            end
            strobe_cnt = 0;
         end else begin
            chk("idle_rdata", data_bus_rd, 32'd0);
            chk("idle_err", 32'(err), 32'd0);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rdata"}, data_bus_rd, 32'd0);
      chk({tag, "_ctl"}, {ack_bus, err, dev_rd, dev_wr, dev_sel}, 32'd0);
      chk({tag, "_addr"}, dev_addr, 32'd0);
      chk({tag, "_be_wdata"}, dev_wdata | 32'(dev_be), 32'd0);
   endtask

   // Issue one arbiter access; the model decides outcome from the 64 KiB region map
   task automatic access(input logic [31:0] addr, input logic rd, input logic wr,
                         input logic cpu, input int lat);
      int   r;
      logic hit, priv, e;
      exp_t x;
      int   cyc;
      r    = int'(addr[31:16]);
      hit  = (r < 4);
      priv = hit && (r == 0) && !cpu;
      e    = !hit || priv || (lat >= DEV_TO);
      cur_region = hit ? r : 0;
      cur_lat    = lat;
      cur_rd     = rd;
      cur_addr   = addr;
      cur_wdata  = $urandom;
      cur_be     = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
         rdv[i] = $urandom;
         dev_rdata[i*32 +: 32] = rdv[i];
      end
      x.err     = e;
      x.data    = e ? 32'hDEAD_BEEF : (rd ? rdv[r] : 32'd0);
      x.strobes = (!hit || priv) ? 0 : ((lat >= DEV_TO) ? DEV_TO : lat + 1);
      sb.push_back(x);
      @(negedge clk);
      add_bus     = addr;
      byte_en     = cur_be;
      data_bus_wr = cur_wdata;
      cpu_bus     = cpu;
      rd_bus      = rd;
      wr_bus      = wr;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!ack_bus && cyc < DEV_TO + 20);
      chk("ack_latency", 32'(cyc), 32'(x.strobes + 1));
      rd_bus  = 1'b0;
      wr_bus  = 1'b0;
      add_bus = $urandom;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [31:0] a;
      int          s;
      int          op;
      reset = 1'b1;
      rd_bus = 1'b0; wr_bus = 1'b0; cpu_bus = 1'b0;
      add_bus = '0; byte_en = '0; data_bus_wr = '0; dev_rdata = '0;
      idle(3);
      check_all_zero("reset");
      reset = 1'b0;
      idle(2);

      access(32'h0001_0010, 1'b1, 1'b0, 1'b1, 2);
      idle(2);
      access(32'h0009_0000, 1'b0, 1'b1, 1'b1, 0);
      idle(1);
      access(32'h0000_0004, 1'b1, 1'b0, 1'b0, 0);
      idle(1);
      access(32'h0000_0004, 1'b1, 1'b0, 1'b1, 1);
      idle(1);
      access(32'h0002_0040, 1'b0, 1'b1, 1'b1, 100000);
      idle(3);
      access(32'h0000_0100, 1'b1, 1'b0, 1'b1, 3);
      idle(1);
      access(32'h0003_0008, 1'b0, 1'b1, 1'b0, 0);
      idle(1);
      access(32'h0001_0000, 1'b1, 1'b1, 1'b0, 1);
      idle(1);

      // Reset in the middle of a long access: nothing pushed, so any ack_bus is flagged
      cur_region = 1; cur_lat = 100000; cur_rd = 1'b1;
      cur_addr = 32'h0001_0020; cur_be = 4'hF; cur_wdata = '0;
      @(negedge clk);
      add_bus = cur_addr; byte_en = cur_be; cpu_bus = 1'b1; rd_bus = 1'b1;
      idle(4);
      chk("pre_reset_dev_rd", 32'(dev_rd), 32'd1);
      #1 reset = 1'b1;
      #1 check_all_zero("mid_reset");
      rd_bus = 1'b0;
      idle(2);
      reset = 1'b0;
      idle(2);
      access(32'h0001_0020, 1'b1, 1'b0, 1'b1, 0);
      idle(1);

      for (int n = 0; n < 50; n++) begin
         s = int'($urandom % 6);
         if (s < 4) a = {16'(s), 16'($urandom)};
         else       a = {16'($urandom_range(4, 65535)), 16'($urandom)};
         op = int'($urandom % 3);
         access(a, op != 1, op != 0, 1'($urandom), ($urandom % 20 == 0) ? 300 : int'($urandom % 5));
         idle(1 + int'($urandom % 3));
      end

      idle(5);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
